// File: rtl/i2c_byte_engine.sv
// I2C master byte stage: clocks 8 data bits MSB-first plus one ACK bit between START and STOP.
// Optional arbitration-loss detection is compiled in with `define I2C_BYTE_ENGINE_ARB_LOST_EN.
module i2c_byte_engine (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [31:0] clock_div,
   input  logic        go,
   input  logic        rw,
   input  logic [7:0]  tx_data,
   input  logic        ack_in,
   input  logic        sda_in,
   output logic        SDA,
   output logic        SCL,
   output logic [7:0]  rx_data,
   output logic        ack_out,
   output logic        busy,
   output logic        done,
   output logic        arb_lost
);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, HOLD, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q;
   logic [31:0] phase_len;
   logic        expire;
   logic [3:0]  bit_cnt_q;
   logic        rw_q;
   logic [7:0]  tx_q;
   logic        ack_q;
   logic [7:0]  rx_shift_q;
   logic        bit_val;
   logic        abort;

   // Handshake: go is a request taken only in IDLE (busy low); any go seen while
   // busy is dropped, and done pulses exactly once per accepted go.
   assign phase_len = (clock_div == 32'd0) ? 32'd1 : clock_div;
   assign expire    = (cnt_q == phase_len - 32'd1);

   always_comb begin
      bit_val = 1'b1;
      if (rw_q)
         bit_val = (bit_cnt_q == 4'd8) ? ack_q : 1'b1;
      else if (bit_cnt_q != 4'd8)
         bit_val = tx_q[3'd7 - bit_cnt_q[2:0]];
   end

`ifdef I2C_BYTE_ENGINE_ARB_LOST_EN
   logic arb_q;

   // Another master pulled SDA low while this one released it.
   assign abort = (state_q == HIGH) && expire && !rw_q && (bit_cnt_q < 4'd8)
                  && bit_val && !sda_in;
   assign arb_lost = arb_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         arb_q <= 1'b0;
      else if (state_q == IDLE && go)
         arb_q <= 1'b0;
      else if (abort)
         arb_q <= 1'b1;
   end
`else
   assign abort    = 1'b0;
   assign arb_lost = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = SETUP;
         SETUP:   if (expire) state_d = HIGH;
         HIGH:    if (abort) state_d = DONE;
                  else if (expire) state_d = HOLD;
         HOLD:    if (expire) state_d = (bit_cnt_q == 4'd8) ? DONE : SETUP;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus pins decode straight from registered state, so they only move at phase edges.
   assign SCL  = (state_q == HIGH);
   assign SDA  = (state_q == SETUP || state_q == HIGH || state_q == HOLD) ? bit_val : 1'b1;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 32'd0;
         bit_cnt_q  <= 4'd0;
         rw_q       <= 1'b0;
         tx_q       <= 8'd0;
         ack_q      <= 1'b0;
         rx_shift_q <= 8'd0;
         rx_data    <= 8'd0;
         ack_out    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE || state_d != state_q)
            cnt_q <= 32'd0;
         else
            cnt_q <= cnt_q + 32'd1;
         case (state_q)
            IDLE: if (go) begin
               rw_q      <= rw;
               tx_q      <= tx_data;
               ack_q     <= ack_in;
               bit_cnt_q <= 4'd0;
            end
            HIGH: if (expire) begin
               if (rw_q && bit_cnt_q < 4'd8)
                  rx_shift_q <= {rx_shift_q[6:0], sda_in};
               if (!rw_q && bit_cnt_q == 4'd8)
                  ack_out <= sda_in;
            end
            HOLD: if (expire) begin
               if (bit_cnt_q < 4'd8)
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               else if (rw_q)
                  rx_data <= rx_shift_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Bench for i2c_byte_engine: a slave model drives sda_in; a scoreboard compares per-byte results.
module tb_i2c_byte_engine;

   localparam int W = 19;  // {arb_lost, SDA bits 0..8, ack_out, rx_data}

   logic        clk = 1'b0;
   logic        n_rst;
   logic [31:0] clock_div;
   logic        go, rw, ack_in, sda_in;
   logic [7:0]  tx_data;
   logic        SDA, SCL, ack_out, busy, done, arb_lost;
   logic [7:0]  rx_data;

   logic [W-1:0] exp_q[$];
   int           n_assert = 0;
   int           n_fail = 0;
   int           done_cnt = 0;
   logic         m_ack;
   logic [7:0]   m_rx;

   i2c_byte_engine dut (
      .clk(clk), .n_rst(n_rst), .clock_div(clock_div), .go(go), .rw(rw),
      .tx_data(tx_data), .ack_in(ack_in), .sda_in(sda_in), .SDA(SDA), .SCL(SCL),
      .rx_data(rx_data), .ack_out(ack_out), .busy(busy), .done(done), .arb_lost(arb_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   // Reference model: what the byte should look like on the bus and in the result registers.
   task automatic push_expected(input logic r, input logic [7:0] d, input logic a, input logic sa);
      if (!r) m_ack = sa;
      else    m_rx  = d;
      exp_q.push_back({1'b0, (r ? {8'hFF, a} : {d, 1'b1}), m_ack, m_rx});
   endtask

   // Drives one go and plays the slave; returns what was seen on the bus.
   task automatic run_xfer(input logic imm, input logic r, input logic [7:0] d, input logic a,
                           input logic [31:0] div, input logic [8:0] slave, input logic go_at_done,
                           output logic [W-1:0] obs, output int lat, output int hmin,
                           output int hmax, output int nhigh, output logic idle_after,
                           output logic tout);
      logic prev;
      int hw, cnt;
      logic [8:0] sbits;
      if (!imm) @(negedge clk);
      clock_div = div; rw = r; tx_data = d; ack_in = a; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      cnt = 1; prev = 1'b0; hw = 0; sbits = 9'h000; nhigh = 0; hmin = 1000; hmax = 0; tout = 1'b0;
      forever begin
         if (SCL) begin
            if (!prev) begin
               if (nhigh < 9) sbits[8-nhigh] = SDA;
               nhigh++;
               hw = 0;
            end
            hw++;
         end else begin
            if (prev) begin
               if (hw < hmin) hmin = hw;
               if (hw > hmax) hmax = hw;
            end
            sda_in = (nhigh < 9) ? slave[8-nhigh] : 1'b1;
         end
         prev = SCL;
         if (done) break;
         if (cnt >= 2000) begin tout = 1'b1; break; end
         @(negedge clk);
         cnt++;
      end
      lat = cnt;
      obs = {arb_lost, sbits, ack_out, rx_data};
      sda_in = 1'b1;
      if (go_at_done) go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      idle_after = !done && !busy;
   endtask

   logic [W-1:0] obs, exp_w;
   int           lat, hmin, hmax, nhigh, d0;
   logic         idle_after, tout;

   task automatic test_reset();
      n_rst = 1'b0; go = 1'b0; rw = 1'b0; tx_data = 8'h00; ack_in = 1'b0; sda_in = 1'b1;
      clock_div = 32'd1; m_ack = 1'b0; m_rx = 8'h00;
      repeat (3) @(negedge clk);
      n_assert++; if ({SCL, SDA, busy, done, rx_data, ack_out, arb_lost} !== {4'b0100, 8'h00, 2'b00}) begin n_fail++; $display("FAIL reset_hold got %b want %b", {SCL, SDA, busy, done, rx_data, ack_out, arb_lost}, {4'b0100, 8'h00, 2'b00}); end
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      n_assert++; if ({SCL, SDA, busy, done, rx_data, ack_out, arb_lost} !== {4'b0100, 8'h00, 2'b00}) begin n_fail++; $display("FAIL reset_release got %b want %b", {SCL, SDA, busy, done, rx_data, ack_out, arb_lost}, {4'b0100, 8'h00, 2'b00}); end
   endtask

   task automatic test_write();
      push_expected(1'b0, 8'hA5, 1'b0, 1'b0);
      run_xfer(1'b0, 1'b0, 8'hA5, 1'b0, 32'd4, {8'hA5, 1'b0}, 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
      exp_w = exp_q.pop_front();
      n_assert++; if (tout) begin n_fail++; $display("FAIL write_timeout got no done want done"); end
      n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL write_result got %h want %h", obs, exp_w); end
      n_assert++; if (lat !== 109) begin n_fail++; $display("FAIL write_latency got %0d want 109", lat); end
      n_assert++; if (hmin !== 4 || hmax !== 4) begin n_fail++; $display("FAIL write_scl_width got %0d..%0d want 4..4", hmin, hmax); end
      n_assert++; if (nhigh !== 9) begin n_fail++; $display("FAIL write_pulses got %0d want 9", nhigh); end
      n_assert++; if (!idle_after) begin n_fail++; $display("FAIL write_idle_after got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_write_nack();
      push_expected(1'b0, 8'h5A, 1'b0, 1'b1);
      run_xfer(1'b0, 1'b0, 8'h5A, 1'b0, 32'd2, {8'h5A, 1'b1}, 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
      exp_w = exp_q.pop_front();
      n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL nack_result got %h want %h", obs, exp_w); end
      n_assert++; if (lat !== 55) begin n_fail++; $display("FAIL nack_latency got %0d want 55", lat); end
   endtask

   task automatic test_read();
      push_expected(1'b1, 8'h3C, 1'b1, 1'b0);
      run_xfer(1'b0, 1'b1, 8'h00, 1'b1, 32'd3, {8'h3C, 1'b1}, 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
      exp_w = exp_q.pop_front();
      n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL read_result got %h want %h", obs, exp_w); end
      n_assert++; if (lat !== 82) begin n_fail++; $display("FAIL read_latency got %0d want 82", lat); end
      n_assert++; if (hmin !== 3 || hmax !== 3) begin n_fail++; $display("FAIL read_scl_width got %0d..%0d want 3..3", hmin, hmax); end
   endtask

   task automatic test_div0();
      push_expected(1'b0, 8'hFF, 1'b0, 1'b0);
      run_xfer(1'b0, 1'b0, 8'hFF, 1'b0, 32'd0, {8'hFF, 1'b0}, 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
      exp_w = exp_q.pop_front();
      n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL div0_result got %h want %h", obs, exp_w); end
      n_assert++; if (lat !== 28) begin n_fail++; $display("FAIL div0_latency got %0d want 28", lat); end
      n_assert++; if (hmin !== 1 || hmax !== 1 || nhigh !== 9) begin n_fail++; $display("FAIL div0_pulses got w=%0d..%0d n=%0d want 1..1 n=9", hmin, hmax, nhigh); end
   endtask

   task automatic test_ignore_go();
      int extra;
      d0 = done_cnt;
      push_expected(1'b0, 8'h3C, 1'b0, 1'b0);
      fork
         run_xfer(1'b0, 1'b0, 8'h3C, 1'b0, 32'd2, {8'h3C, 1'b0}, 1'b1, obs, lat, hmin, hmax, nhigh, idle_after, tout);
         begin
            repeat (20) @(negedge clk);
            go = 1'b1; tx_data = 8'h00; rw = 1'b1;
            @(negedge clk);
            go = 1'b0;
         end
      join
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      exp_w = exp_q.pop_front();
      n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL ignore_result got %h want %h", obs, exp_w); end
      n_assert++; if (lat !== 55) begin n_fail++; $display("FAIL ignore_latency got %0d want 55", lat); end
      n_assert++; if (!idle_after || extra !== 0) begin n_fail++; $display("FAIL ignore_go_done got idle=%b busy_cycles=%0d want 1 0", idle_after, extra); end
      n_assert++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      clock_div = 32'd3; rw = 1'b0; tx_data = 8'h96; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (49) @(negedge clk);
      n_assert++; if (SCL !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got SCL=%b want 1", SCL); end
      d0 = done_cnt;
      #2 n_rst = 1'b0;
      #1;
      n_assert++; if ({SCL, SDA, busy} !== 3'b010) begin n_fail++; $display("FAIL midrst_pins got %b want 010", {SCL, SDA, busy}); end
      n_assert++; if ({rx_data, ack_out} !== 9'h000) begin n_fail++; $display("FAIL midrst_regs got %h want 000", {rx_data, ack_out}); end
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      m_ack = 1'b0; m_rx = 8'h00;
      repeat (2) @(negedge clk);
      n_assert++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midrst_no_done got %0d want %0d", done_cnt, d0); end
      push_expected(1'b0, 8'h96, 1'b0, 1'b0);
      run_xfer(1'b0, 1'b0, 8'h96, 1'b0, 32'd3, {8'h96, 1'b0}, 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
      exp_w = exp_q.pop_front();
      n_assert++; if (obs !== exp_w || lat !== 82) begin n_fail++; $display("FAIL midrst_after got %h lat %0d want %h lat 82", obs, lat, exp_w); end
   endtask

   task automatic test_arb();
      int exp_lat;
`ifdef I2C_BYTE_ENGINE_ARB_LOST_EN
      exp_q.push_back({1'b1, 9'h100, m_ack, m_rx});
      exp_lat = 5;
`else
      push_expected(1'b0, 8'h80, 1'b0, 1'b0);
      exp_lat = 55;
`endif
      run_xfer(1'b0, 1'b0, 8'h80, 1'b0, 32'd2, 9'h000, 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
      exp_w = exp_q.pop_front();
      n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL arb_result got %h want %h", obs, exp_w); end
      n_assert++; if (lat !== exp_lat) begin n_fail++; $display("FAIL arb_latency got %0d want %0d", lat, exp_lat); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  d;
      logic        r, a, sa;
      logic [31:0] div;
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         r = 1'($urandom_range(0, 1));
         a = 1'($urandom_range(0, 1));
         sa = 1'($urandom_range(0, 1));
         div = 32'($urandom_range(1, 3));
         push_expected(r, d, a, sa);
         run_xfer(i != 0, r, d, a, div, (r ? {d, 1'b1} : {d, sa}), 1'b0, obs, lat, hmin, hmax, nhigh, idle_after, tout);
         exp_w = exp_q.pop_front();
         n_assert++; if (obs !== exp_w) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", i, obs, exp_w); end
         n_assert++; if (lat !== 1 + 27 * int'(div)) begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, 1 + 27 * int'(div)); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_write_nack();
      test_read();
      test_div0();
      test_ignore_go();
      test_reset_mid();
      test_arb();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
